// File: rtl/sent_rx_serial_assembler.sv
// SENT serial message assembler.
// Gathers status-nibble bits 2/3 from consecutive fast frames into short (16-frame)
// or enhanced (18-frame) serial messages, hands each message to the downstream
// CRC checker, and publishes the decoded ID/data once the checker approves it.
//
// Assembly FSM
//   state     | meaning
//   S_HUNT    | waiting for a start pattern (short: bit3=1, enhanced: >=6 ones then 0)
//   S_COLLECT | gathering the remaining frames of a message
// Request FSM
//   state     | meaning
//   R_IDLE    | no message pending at the checker
//   R_WAIT    | message presented to the checker, waiting for its verdict
module sent_rx_serial_assembler #(
    parameter int CRC_TIMEOUT = 63
) (
    input  logic        clk_rx,
    input  logic        reset_n_rx,
    input  logic        serial_mode,
    input  logic        status_valid,
    input  logic [3:0]  status_nibble,
    input  logic        frame_crc_ok,
    output logic [2:0]  enable_crc_check_serial,
    output logic [29:0] data_channel_check_crc,
    input  logic [1:0]  crc_check_done,
    input  logic        valid_data_serial,
    input  logic        valid_data_enhanced,
    output logic [7:0]  msg_id,
    output logic [15:0] msg_data,
    output logic        msg_cfg,
    output logic        msg_valid,
    output logic        msg_error,
    output logic        msg_overrun
);

    localparam int TW = $clog2(CRC_TIMEOUT + 1);

    localparam logic [0:0] S_HUNT    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;
    localparam logic [0:0] R_IDLE    = 1'b0;
    localparam logic [0:0] R_WAIT    = 1'b1;

    logic [0:0]    asm_state;
    logic          mode_q;
    logic [4:0]    frame_cnt;
    logic [2:0]    ones_cnt;
    logic [5:0]    roll;
    logic [14:0]   short_sh;
    logic [21:0]   ilv;
    logic [5:0]    crc6;

    logic [0:0]    req_state;
    logic          req_mode;
    logic [TW-1:0] tmo_cnt;

    logic          bit2;
    logic          bit3;
    logic          frame_ok;
    logic          mode_eff;
    logic          done_short;
    logic          done_enh;
    logic          enh_frame_err;
    logic          asm_done;
    logic [29:0]   snap;

    logic [1:0]    exp_done;
    logic          done_hit;
    logic          crc_good;
    logic          tmo_hit;
    logic          req_free;

    logic [7:0]    dec_id;
    logic [15:0]   dec_data;
    logic          dec_cfg;

    // Bits 1:0 of the status nibble carry nothing serial.
    logic          unused_nib;
    assign unused_nib = ^status_nibble[1:0];

    assign bit2     = status_nibble[2];
    assign bit3     = status_nibble[3];
    assign frame_ok = status_valid && frame_crc_ok;
    // While hunting the pin decides directly, so the mode that starts a message is the one kept for it.
    assign mode_eff = (asm_state == S_HUNT) ? serial_mode : mode_q;

    assign done_short    = frame_ok && (asm_state == S_COLLECT) && !mode_q && !bit3
                           && (frame_cnt == 5'd15);
    assign done_enh      = frame_ok && (asm_state == S_COLLECT) && mode_q && !bit3
                           && (frame_cnt == 5'd17);
    assign enh_frame_err = frame_ok && (asm_state == S_COLLECT) && mode_q && bit3
                           && ((frame_cnt == 5'd12) || (frame_cnt == 5'd17));
    assign asm_done      = done_short || done_enh;
    assign snap          = mode_q ? {ilv, bit2, bit3, crc6} : {14'd0, short_sh, bit2};

    assign exp_done = req_mode ? 2'b11 : 2'b10;
    assign done_hit = (req_state == R_WAIT) && (crc_check_done == exp_done);
    assign crc_good = req_mode ? valid_data_enhanced : valid_data_serial;
    assign tmo_hit  = (req_state == R_WAIT) && !done_hit && (tmo_cnt == TW'(1));
    // A verdict or timeout in the same cycle frees the slot for a message completing now.
    assign req_free = (req_state == R_IDLE) || done_hit || tmo_hit;

    assign enable_crc_check_serial = (req_state == R_WAIT) ? {2'b10, req_mode} : 3'b000;

    // Decode the held message; the snapshot stays stable for the whole request.
    always_comb begin
        dec_id   = '0;
        dec_data = '0;
        dec_cfg  = 1'b0;
        if (!req_mode) begin
            dec_id   = {4'd0, data_channel_check_crc[15:12]};
            dec_data = {8'd0, data_channel_check_crc[11:4]};
        end else begin
            dec_cfg = data_channel_check_crc[26];
            for (int i = 0; i < 12; i++) begin
                dec_data[11-i] = data_channel_check_crc[29-2*i];
            end
            if (data_channel_check_crc[26]) begin
                dec_id[3:0]     = {data_channel_check_crc[24], data_channel_check_crc[22],
                                   data_channel_check_crc[20], data_channel_check_crc[18]};
                dec_data[15:12] = {data_channel_check_crc[14], data_channel_check_crc[12],
                                   data_channel_check_crc[10], data_channel_check_crc[8]};
            end else begin
                dec_id = {data_channel_check_crc[24], data_channel_check_crc[22],
                          data_channel_check_crc[20], data_channel_check_crc[18],
                          data_channel_check_crc[14], data_channel_check_crc[12],
                          data_channel_check_crc[10], data_channel_check_crc[8]};
            end
        end
    end

    // Assembly FSM: frame counting, start-pattern hunting and bit collection.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            asm_state <= S_HUNT;
            mode_q    <= 1'b0;
            frame_cnt <= '0;
            ones_cnt  <= '0;
            roll      <= '0;
            short_sh  <= '0;
            ilv       <= '0;
            crc6      <= '0;
        end else begin
            if (asm_state == S_HUNT) begin
                mode_q <= serial_mode;
            end
            if (status_valid) begin
                if (!frame_crc_ok) begin
                    asm_state <= S_HUNT;
                    frame_cnt <= '0;
                    ones_cnt  <= '0;
                    roll      <= '0;
                    short_sh  <= '0;
                    ilv       <= '0;
                    crc6      <= '0;
                end else if (asm_state == S_HUNT) begin
                    if (!mode_eff) begin
                        if (bit3) begin
                            asm_state <= S_COLLECT;
                            frame_cnt <= 5'd1;
                            short_sh  <= {14'd0, bit2};
                        end
                    end else begin
                        roll <= {roll[4:0], bit2};
                        if (bit3) begin
                            if (ones_cnt != 3'd7) begin
                                ones_cnt <= ones_cnt + 3'd1;
                            end
                        end else if (ones_cnt >= 3'd6) begin
                            asm_state <= S_COLLECT;
                            frame_cnt <= 5'd7;
                            crc6      <= roll;
                            ilv       <= {20'd0, bit2, bit3};
                            ones_cnt  <= '0;
                        end else begin
                            ones_cnt <= '0;
                        end
                    end
                end else if (!mode_q) begin
                    if (bit3) begin
                        frame_cnt <= 5'd1;
                        short_sh  <= {14'd0, bit2};
                    end else begin
                        short_sh <= {short_sh[13:0], bit2};
                        if (frame_cnt == 5'd15) begin
                            asm_state <= S_HUNT;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 5'd1;
                        end
                    end
                end else begin
                    ilv <= {ilv[19:0], bit2, bit3};
                    if (enh_frame_err || (frame_cnt == 5'd17)) begin
                        asm_state <= S_HUNT;
                        frame_cnt <= '0;
                        ones_cnt  <= '0;
                    end else begin
                        frame_cnt <= frame_cnt + 5'd1;
                    end
                end
            end
        end
    end

    // Request FSM: hand snapshots to the checker, collect verdicts, publish results.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            req_state              <= R_IDLE;
            req_mode               <= 1'b0;
            tmo_cnt                <= '0;
            data_channel_check_crc <= '0;
            msg_id                 <= '0;
            msg_data               <= '0;
            msg_cfg                <= 1'b0;
            msg_valid              <= 1'b0;
            msg_error              <= 1'b0;
            msg_overrun            <= 1'b0;
        end else begin
            msg_valid   <= 1'b0;
            msg_error   <= enh_frame_err;
            msg_overrun <= 1'b0;
            if (req_state == R_WAIT) begin
                tmo_cnt <= tmo_cnt - TW'(1);
            end
            if (done_hit) begin
                if (crc_good) begin
                    msg_valid <= 1'b1;
                    msg_id    <= dec_id;
                    msg_data  <= dec_data;
                    msg_cfg   <= dec_cfg;
                end else begin
                    msg_error <= 1'b1;
                end
            end
            if (tmo_hit) begin
                msg_error <= 1'b1;
            end
            if (done_hit || tmo_hit) begin
                req_state <= R_IDLE;
            end
            if (asm_done) begin
                if (req_free) begin
                    req_state              <= R_WAIT;
                    req_mode               <= mode_q;
                    data_channel_check_crc <= snap;
                    tmo_cnt                <= TW'(CRC_TIMEOUT);
                end else begin
                    msg_overrun <= 1'b1;
                end
            end
        end
    end

endmodule
